// File: rtl/even_parity_check_if.sv
// Handshake bundle for the even-parity checker: encoded word in,
// checked data byte out, plus error pulse, error count and count clear.
interface even_parity_check_if #(
  parameter int CNT_W = 8
) ();
  logic [15:0]      W;
  logic             W_VALID;
  logic             W_READY;
  logic [7:0]       D;
  logic             D_VALID;
  logic             D_READY;
  logic             ERR;
  logic [CNT_W-1:0] ERR_CNT;
  logic             ERR_CLR;

  modport master (
    output W, W_VALID, D_READY, ERR_CLR,
    input  W_READY, D, D_VALID, ERR, ERR_CNT
  );

  modport slave (
    input  W, W_VALID, D_READY, ERR_CLR,
    output W_READY, D, D_VALID, ERR, ERR_CNT
  );
endinterface

// File: rtl/even_parity_check.sv
// Even-parity checker: accepts encoded words, buffers good data bytes in a FIFO
// and counts dropped words. Optional macro EVEN_PARITY_STRICT_RSVD_EN also rejects non-zero W[14:8].
module even_parity_check #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic             CLK,
  input logic             RST,
  even_parity_check_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ZERO_OCC = {OCC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic parity_bad(input logic parity, input logic [7:0] data);
    return ^{parity, data};
  endfunction

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             ready_r;
  logic             valid_r;
  logic [7:0]       d_r;
  logic             err_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic             accept_s;
  logic             bad_s;
  logic             push_s;
  logic             pop_s;
  logic             reject_s;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [OCC_W-1:0] occ_next_s;
  logic [CNT_W-1:0] err_cnt_next_s;
  logic [7:0]       head_next_s;

  // Handshake decode and next-state computation.
  always_comb begin
    accept_s = bus.W_VALID & ready_r;
`ifdef EVEN_PARITY_STRICT_RSVD_EN
    bad_s = parity_bad(bus.W[15], bus.W[7:0]) | (|bus.W[14:8]);
`else
    bad_s = parity_bad(bus.W[15], bus.W[7:0]);
`endif
    push_s   = accept_s & ~bad_s;
    reject_s = accept_s & bad_s;
    pop_s    = valid_r & bus.D_READY;

    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    occ_next_s = occ_r + OCC_W'(push_s) - OCC_W'(pop_s);

    if (bus.ERR_CLR) begin
      err_cnt_next_s = reject_s ? CNT_ONE : CNT_ZERO;
    end else if (reject_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_next_s = err_cnt_r + CNT_ONE;
    end else begin
      err_cnt_next_s = err_cnt_r;
    end

    // A push can only land on the next head slot when the FIFO drains to empty.
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = bus.W[7:0];
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage, pointers, registered outputs and error counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= ZERO_OCC;
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      d_r       <= 8'h00;
      err_r     <= 1'b0;
      err_cnt_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.W[7:0];
      end
      wr_ptr_r  <= wr_ptr_next_s;
      rd_ptr_r  <= rd_ptr_next_s;
      occ_r     <= occ_next_s;
      ready_r   <= (occ_next_s != FULL_OCC);
      valid_r   <= (occ_next_s != ZERO_OCC);
      d_r       <= head_next_s;
      err_r     <= reject_s;
      err_cnt_r <= err_cnt_next_s;
    end
  end

  assign bus.W_READY = ready_r;
  assign bus.D_VALID = valid_r;
  assign bus.D       = d_r;
  assign bus.ERR     = err_r;
  assign bus.ERR_CNT = err_cnt_r;
endmodule

// File: tb/tb_even_parity_check.sv
// Bench for even_parity_check: vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_even_parity_check;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
`ifdef EVEN_PARITY_STRICT_RSVD_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  even_parity_check_if #(.CNT_W(CNT_W)) bus ();
  even_parity_check #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  int  m_cnt   = 0;
  bit  m_err   = 1'b0;
  bit  m_ready = 1'b0;
  bit  m_dzero = 1'b0;

  typedef struct {
    logic [15:0] w;
    bit          exp_err;
    logic [7:0]  exp_d;
  } vec_t;

  function automatic bit is_bad(input logic [15:0] w);
    int ones;
    ones = $countones({w[15], w[7:0]});
    return ((ones % 2) != 0) || (STRICT && (w[14:8] != 7'd0));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the reference model at the edge, compare at the falling edge.
  task automatic tick();
    bit acc, pop, bad;
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      m_cnt = 0; m_err = 1'b0; m_ready = 1'b0; m_dzero = 1'b1;
    end else begin
      acc = bus.W_VALID && m_ready;
      pop = (mq.size() > 0) && bus.D_READY;
      bad = is_bad(bus.W);
      if (pop) void'(mq.pop_front());
      if (acc && !bad) mq.push_back(bus.W[7:0]);
      m_err = acc && bad;
      if (bus.ERR_CLR) m_cnt = m_err ? 1 : 0;
      else if (m_err && m_cnt < CNT_SAT) m_cnt++;
      m_ready = mq.size() < DEPTH;
      m_dzero = 1'b0;
    end
    @(negedge CLK);
    check("w_ready", bus.W_READY, m_ready);
    check("d_valid", bus.D_VALID, mq.size() > 0);
    check("err", bus.ERR, m_err);
    check("err_cnt", bus.ERR_CNT, m_cnt);
    if (mq.size() > 0) check("d", bus.D, mq[0]);
    else if (m_dzero) check("d_reset", bus.D, 0);
  endtask

  task automatic drive(input logic [15:0] w, input bit v, input bit dr, input bit clr);
    bus.W = w; bus.W_VALID = v; bus.D_READY = dr; bus.ERR_CLR = clr;
  endtask

  initial begin
    vec_t vecs[10];
    logic [15:0] words[5];
    logic [7:0]  got[$];
    int          sent;
    logic [7:0]  data;
    logic [6:0]  rsvd;
    logic        par;

    vecs[0] = '{16'h00AA, 1'b0, 8'hAA};
    vecs[1] = '{16'h00BB, 1'b0, 8'hBB};
    vecs[2] = '{16'h80AA, 1'b1, 8'h00};
    vecs[3] = '{16'h8001, 1'b0, 8'h01};
    vecs[4] = '{16'h0001, 1'b1, 8'h00};
    vecs[5] = '{16'h00FF, 1'b0, 8'hFF};
    vecs[6] = '{16'h80FE, 1'b0, 8'hFE};
    vecs[7] = '{16'h8000, 1'b1, 8'h00};
    vecs[8] = '{16'h01AA, STRICT, 8'hAA};
    vecs[9] = '{16'h7F00, STRICT, 8'h00};
    words   = '{16'h0003, 16'h0005, 16'h0006, 16'h0009, 16'h800B};

    RST = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    tick();
    tick();
    check("rst_ready_low", bus.W_READY, 0);
    RST = 1'b0;
    tick();
    check("ready_after_rst", bus.W_READY, 1);

    // Table of single words, FIFO drained between entries.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].w, 1'b1, 1'b1, 1'b0);
      tick();
      check("vec_err", bus.ERR, vecs[i].exp_err);
      check("vec_valid", bus.D_VALID, !vecs[i].exp_err);
      if (!vecs[i].exp_err) check("vec_d", bus.D, vecs[i].exp_d);
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
    end

    // Fill to full with consumer stalled, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(words[i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("full_ready", bus.W_READY, 0);
    drive(words[4], 1'b1, 1'b0, 1'b0);
    tick();
    check("held_ready", bus.W_READY, 0);
    check("held_head", bus.D, words[0][7:0]);
    bus.D_READY = 1'b1;
    sent = 0;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (bus.D_VALID) got.push_back(bus.D);
      if (bus.W_READY && bus.W_VALID) sent = 1;
      tick();
      if (sent != 0) bus.W_VALID = 1'b0;
    end
    check("drain_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("drain_order", got[i], words[i][7:0]);

    // Saturation then clear coinciding with a bad word.
    drive(16'h80AA, 1'b1, 1'b1, 1'b0);
    repeat (300) tick();
    check("sat_cnt", bus.ERR_CNT, CNT_SAT);
    bus.ERR_CLR = 1'b1;
    tick();
    check("clr_with_bad_cnt", bus.ERR_CNT, 1);
    check("clr_with_bad_err", bus.ERR, 1);
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    check("err_single_pulse", bus.ERR, 0);

    // Mid-stream reset with 3 entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive(words[i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("three_valid", bus.D_VALID, 1);
    RST = 1'b1;
    tick();
    check("mid_rst_valid", bus.D_VALID, 0);
    check("mid_rst_cnt", bus.ERR_CNT, 0);
    RST = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("mid_rst_ready", bus.W_READY, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      data = 8'($urandom);
      rsvd = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'd0;
      par  = ^data;
      if ($urandom_range(0, 3) == 0) par = ~par;
      drive({par, rsvd, data}, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
